// File: rtl/bit_pixel_pkg.sv
// Shared types and helpers for the bit-pixel writer and reader.
// frame_words() is used on both sides so the two agree on the buffer base addresses.
package bit_pixel_pkg;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_WRITING  = 1'b1
    } state_e;

    localparam int PIXELS_PER_WORD = 8;

    function automatic int frame_words(input int width, input int height);
        return (width * height) / PIXELS_PER_WORD;
    endfunction

endpackage

// File: rtl/bit_byte_packer.sv
// Packs binarized pixels LSB-first into bytes. A restart drops any partial byte,
// and a bit presented in the same cycle as the restart becomes bit 0 of a new byte.
module bit_byte_packer
    import bit_pixel_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       restart_i,
    input  logic                       bit_valid_i,
    input  logic                       bit_i,
    output logic [PIXELS_PER_WORD-1:0] packed_o,
    output logic                       word_strobe_o
);

    localparam int CNT_W = $clog2(PIXELS_PER_WORD);

    logic [PIXELS_PER_WORD-1:0] shift_q, shift_d, shift_base;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_base;

    // New bits enter at the MSB and shift right, so the first pixel of a group ends in bit 0.
    always_comb begin
        shift_base    = restart_i ? '0 : shift_q;
        cnt_base      = restart_i ? '0 : cnt_q;
        packed_o      = {bit_i, shift_base[PIXELS_PER_WORD-1:1]};
        word_strobe_o = bit_valid_i && (cnt_base == CNT_W'(PIXELS_PER_WORD - 1));
        shift_d       = shift_base;
        cnt_d         = cnt_base;
        if (bit_valid_i) begin
            shift_d = packed_o;
            cnt_d   = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/bit_pixel_writer.sv
// Binarizes one region's pixel stream and writes packed bytes into a dual-buffered bit RAM.
// Optional macro BIT_PIXEL_WRITER_ERRCNT_EN adds the frame_err_count output.
//
//   state       | meaning
//   ST_WAIT_SOF | idle; pixels ignored until a valid SOF pixel arrives
//   ST_WRITING  | packing pixels of the current frame into the active buffer
module bit_pixel_writer
    import bit_pixel_pkg::*;
#(
    parameter int image_width  = 240,
    parameter int image_height = 480
) (
    input  logic        pclk,
    input  logic        pclk_reset_n,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [7:0]  threshold,
    output logic [15:0] wr_address,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic [3:0]  image_number,
    output logic        frame_done,
    output logic        busy
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
    ,
    output logic [15:0] frame_err_count
`endif
);

    localparam int                    FRAME_WORDS = frame_words(image_width, image_height);
    localparam int                    TOTAL_PIX   = image_width * image_height;
    localparam int                    PIX_CNT_W   = $clog2(TOTAL_PIX);
    localparam logic [15:0]           BUF1_BASE   = 16'(FRAME_WORDS);
    localparam logic [PIX_CNT_W-1:0]  LAST_PIX    = PIX_CNT_W'(TOTAL_PIX - 1);

    state_e                 state_q;
    logic [PIX_CNT_W-1:0]   pix_cnt_q;
    logic [15:0]            word_idx_q;
    logic                   buf_q;
    logic [3:0]             image_q;
    logic                   wr_en_q;
    logic [7:0]             wr_data_q;
    logic [15:0]            wr_addr_q;
    logic                   frame_done_q;

    logic                   sof_valid;
    logic                   accept;
    logic                   restart;
    logic                   pix_bit;
    logic [PIX_CNT_W-1:0]   pix_idx;
    logic [15:0]            word_cur;
    logic [15:0]            base;
    logic                   last_pix;
    logic [7:0]             packed_byte;
    logic                   word_strobe;

    // An SOF pixel always becomes pixel 0, whether it starts a frame or aborts one.
    always_comb begin
        sof_valid = pix_valid && pix_sof;
        accept    = pix_valid && ((state_q == ST_WRITING) || pix_sof);
        restart   = (state_q == ST_WAIT_SOF) || sof_valid;
        pix_bit   = (pix_data >= threshold);
        pix_idx   = sof_valid ? '0 : pix_cnt_q;
        word_cur  = sof_valid ? '0 : word_idx_q;
        base      = buf_q ? BUF1_BASE : 16'd0;
        last_pix  = accept && (pix_idx == LAST_PIX);
    end

    bit_byte_packer u_packer (
        .clk_i         (pclk),
        .rst_ni        (pclk_reset_n),
        .restart_i     (restart),
        .bit_valid_i   (accept),
        .bit_i         (pix_bit),
        .packed_o      (packed_byte),
        .word_strobe_o (word_strobe)
    );

    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            state_q      <= ST_WAIT_SOF;
            pix_cnt_q    <= '0;
            word_idx_q   <= '0;
            buf_q        <= 1'b0;
            image_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                if (word_strobe) begin
                    wr_en_q    <= 1'b1;
                    wr_data_q  <= packed_byte;
                    wr_addr_q  <= base + word_cur;
                    word_idx_q <= word_cur + 16'd1;
                end else if (sof_valid) begin
                    word_idx_q <= '0;
                end
                // The last byte still lands in the old buffer: base above uses buf_q before the flip.
                if (last_pix) begin
                    state_q      <= ST_WAIT_SOF;
                    pix_cnt_q    <= '0;
                    word_idx_q   <= '0;
                    image_q      <= image_q + 4'd1;
                    buf_q        <= ~buf_q;
                    frame_done_q <= 1'b1;
                end else begin
                    state_q   <= ST_WRITING;
                    pix_cnt_q <= pix_idx + PIX_CNT_W'(1);
                end
            end
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_data      = wr_data_q;
    assign wr_address   = wr_addr_q;
    assign image_number = image_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q == ST_WRITING);

`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic        err_event;

    // Counts aborted frames and SOF flags that arrive without a valid pixel.
    assign err_event = (sof_valid && (state_q == ST_WRITING)) || (pix_sof && !pix_valid);

    always_ff @(posedge pclk or negedge pclk_reset_n) begin
        if (!pclk_reset_n) begin
            err_cnt_q <= '0;
        end else if (err_event && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_bit_pixel_writer.sv
// Directed bench for bit_pixel_writer on an 8x2 frame (two bytes per frame, buffer bases 0 and 2).
module tb_bit_pixel_writer;
    import bit_pixel_pkg::*;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int FW = frame_words(W, H);

    logic        pclk;
    logic        pclk_reset_n;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic [7:0]  threshold;
    logic [15:0] wr_address;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [3:0]  image_number;
    logic        frame_done;
    logic        busy;
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
    logic [15:0] frame_err_count;
`endif

    bit_pixel_writer #(.image_width(W), .image_height(H)) dut (
        .pclk         (pclk),
        .pclk_reset_n (pclk_reset_n),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_sof      (pix_sof),
        .threshold    (threshold),
        .wr_address   (wr_address),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .image_number (image_number),
        .frame_done   (frame_done),
        .busy         (busy)
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
        ,
        .frame_err_count (frame_err_count)
`endif
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    logic [23:0] wq[$];
    logic [23:0] eq[$];

    always @(negedge pclk) begin
        if (wr_en) wq.push_back({wr_address, wr_data});
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel cycle; after a cycle without a valid pixel no write may appear.
    task automatic step(input logic v, input logic s, input logic [7:0] d, input logic [7:0] t);
        pix_valid = v;
        pix_sof   = s;
        pix_data  = d;
        threshold = t;
        @(posedge pclk);
        #1;
        if (!v) check("no_write_after_gap", {31'd0, wr_en}, 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] t, input logic [63:0] pix, input logic sof);
        for (int k = 0; k < 8; k++) step(1'b1, sof && (k == 0), pix[8*k +: 8], t);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 8'd128);
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, "_count"}, wq.size(), eq.size());
        n = (wq.size() < eq.size()) ? wq.size() : eq.size();
        for (int i = 0; i < n; i++) check(name, {8'd0, wq[i]}, {8'd0, eq[i]});
        wq.delete();
        eq.delete();
    endtask

    typedef struct {
        logic [7:0]  thr;
        logic [63:0] pix;
        logic [7:0]  exp_data;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl[8];

    localparam logic [63:0] ALL_HI = 64'hC8C8_C8C8_C8C8_C8C8;
    localparam logic [63:0] ALT_AA = 64'hC800_C800_C800_C800;
    localparam logic [63:0] ALT_55 = 64'h00C8_00C8_00C8_00C8;

    int fd_before;
    int img_model;

    initial begin
        tbl[0] = '{8'd128, ALT_AA, 8'hAA, 16'd0};
        tbl[1] = '{8'd128, ALT_AA, 8'hAA, 16'd1};
        tbl[2] = '{8'd128, ALT_AA, 8'hAA, 16'd2};
        tbl[3] = '{8'd128, ALT_AA, 8'hAA, 16'd3};
        tbl[4] = '{8'h80, 64'hC801_8081_00FF_7F80, 8'hB5, 16'd0};
        tbl[5] = '{8'h00, 64'h0706_0504_0302_0100, 8'hFF, 16'd1};
        tbl[6] = '{8'hFF, 64'hFEFF_FEFF_FEFF_FEFF, 8'h55, 16'd2};
        tbl[7] = '{8'h10, 64'hFF00_0000_100F_0F10, 8'h89, 16'd3};

        pclk_reset_n = 1'b0;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_data  = 8'h00;
        threshold = 8'd128;
        idle(3);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {16'd0, wr_address}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_image", {28'd0, image_number}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        pclk_reset_n = 1'b1;

        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'hC8, 8'd128);
        check("pre_sof_busy", {31'd0, busy}, 32'd0);
        idle(2);
        compare_writes("pre_sof_writes");

        // Table frames: two vectors per frame, buffers alternate 0/FW.
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 2; b++) begin
                send_byte(tbl[2*f+b].thr, tbl[2*f+b].pix, b == 0);
                eq.push_back({tbl[2*f+b].exp_addr, tbl[2*f+b].exp_data});
                if (b == 0) check("busy_mid_frame", {31'd0, busy}, 32'd1);
            end
            idle(2);
            check("table_image", {28'd0, image_number}, f + 1);
            check("table_frame_done", fd_cnt, f + 1);
        end
        compare_writes("table_writes");

        // Early SOF five pixels into the second byte of a frame.
        send_byte(8'd128, ALL_HI, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'hC8, 8'd128);
        check("abort_image_unchanged", {28'd0, image_number}, 32'd4);
        send_byte(8'd128, ALT_AA, 1'b1);
        send_byte(8'd128, ALT_AA, 1'b0);
        idle(2);
        eq.push_back({16'd0, 8'hFF});
        eq.push_back({16'd0, 8'hAA});
        eq.push_back({16'd1, 8'hAA});
        compare_writes("abort_writes");
        check("abort_image", {28'd0, image_number}, 32'd5);
        check("abort_frame_done", fd_cnt, 32'd5);
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
        check("errcnt_abort", {16'd0, frame_err_count}, 32'd1);
`endif

        // Sparse frame with a gap after every pixel; one gap carries SOF without valid.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 8; k++) begin
                step(1'b1, (b == 0) && (k == 0), tbl[4+b].pix[8*k +: 8], tbl[4+b].thr);
                step(1'b0, (b == 0) && (k == 3), 8'h00, tbl[4+b].thr);
            end
        end
        idle(1);
        eq.push_back({16'(FW), 8'hB5});
        eq.push_back({16'(FW + 1), 8'hFF});
        compare_writes("sparse_writes");
        check("sparse_image", {28'd0, image_number}, 32'd6);
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
        check("errcnt_sof_no_valid", {16'd0, frame_err_count}, 32'd2);
`endif

        // Back-to-back frames: next SOF in the cycle right after completion.
        fd_before = fd_cnt;
        send_byte(8'd128, ALL_HI, 1'b1);
        send_byte(8'd128, ALL_HI, 1'b0);
        send_byte(8'd128, ALT_55, 1'b1);
        send_byte(8'd128, ALT_55, 1'b0);
        idle(2);
        eq.push_back({16'd0, 8'hFF});
        eq.push_back({16'd1, 8'hFF});
        eq.push_back({16'(FW), 8'h55});
        eq.push_back({16'(FW + 1), 8'h55});
        compare_writes("b2b_writes");
        check("b2b_image", {28'd0, image_number}, 32'd8);
        check("b2b_frame_done", fd_cnt - fd_before, 32'd2);

        // Async reset while the third byte write is on the bus.
        send_byte(8'd128, ALL_HI, 1'b1);
        send_byte(8'd128, ALL_HI, 1'b0);
        send_byte(8'd128, ALL_HI, 1'b1);
        check("pre_reset_wr_en", {31'd0, wr_en}, 32'd1);
        pclk_reset_n = 1'b0;
        #1;
        check("async_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("async_rst_wr_addr", {16'd0, wr_address}, 32'd0);
        check("async_rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("async_rst_image", {28'd0, image_number}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        eq.push_back({16'd0, 8'hFF});
        eq.push_back({16'd1, 8'hFF});
        compare_writes("pre_reset_writes");
        for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 8'hC8, 8'd128);
        pclk_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'hC8, 8'd128);
        check("post_reset_ignored_busy", {31'd0, busy}, 32'd0);
        send_byte(8'd128, ALT_AA, 1'b1);
        send_byte(8'd128, ALT_AA, 1'b0);
        idle(2);
        eq.push_back({16'd0, 8'hAA});
        eq.push_back({16'd1, 8'hAA});
        compare_writes("post_reset_writes");
        check("post_reset_image", {28'd0, image_number}, 32'd1);
`ifdef BIT_PIXEL_WRITER_ERRCNT_EN
        check("errcnt_after_reset", {16'd0, frame_err_count}, 32'd0);
`endif

        // Sixteen consecutive frames: image_number wraps, bases alternate.
        img_model = 1;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'd128, ALL_HI, 1'b1);
            send_byte(8'd128, ALT_AA, 1'b0);
            eq.push_back({16'(((img_model % 2) == 1) ? FW : 0), 8'hFF});
            eq.push_back({16'(((img_model % 2) == 1) ? FW + 1 : 1), 8'hAA});
            img_model = (img_model + 1) % 16;
            check("wrap_image", {28'd0, image_number}, img_model);
        end
        idle(2);
        compare_writes("wrap_writes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_pixel_writer.md
Name: bit_pixel_writer

Overview:
- Upstream stage of the bit-pixel read path.
- Consumes one camera region's 8-bit grayscale pixel stream and binarizes each pixel against a threshold.
- Packs 8 result bits per byte and writes the bytes into that region's dual-buffered bit RAM.
- After each complete frame it flips buffers and increments a 4-bit image_number, which tells the downstream reader that a new frame is ready.
- One instance per region: left, centerleft and right.

Parameters:
- image_width, 240, pixels per row; must be a multiple of 8 (304 for the centre region).
- image_height, 480, rows per frame.
- (derived) frame_words = image_width*image_height/8; must satisfy 2*frame_words <= 65536.

Ports:
- pclk  in  1  pixel clock.
- pclk_reset_n  in  1  asynchronous, active-low reset.
- pix_data  in  8  grayscale pixel.
- pix_valid  in  1  pix_data valid this cycle; no backpressure, every valid pixel is accepted.
- pix_sof  in  1  first pixel of frame; qualified by pix_valid.
- threshold  in  8  binarization threshold, sampled per pixel.
- wr_address  out  16  RAM byte address.
- wr_data  out  8  packed bits.
- wr_en  out  1  RAM write strobe.
- image_number  out  4  completed-frame counter, consumed by the reader.
- frame_done  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high in ST_WRITING.

Behaviour:
- Reset (async assert, sync deassert in the system): all outputs 0; buf_index=0; state ST_WAIT_SOF; pixel counter 0; shift register 0.
- Reset mid-frame discards the partial frame. image_number returns to 0, so the downstream reader must share the reset.
- Binarize: bit = (pix_data >= threshold). Pixel k of each group of 8 (k=0 first) lands in wr_data[k], LSB-first.
- Byte address: base + word_index, where base = buf_index ? frame_words : 0.
- ST_WAIT_SOF:
  - Ignore pixels until pix_valid && pix_sof.
  - That pixel is pixel 0 of the frame; go to ST_WRITING.
- ST_WRITING:
  - Each valid pixel shifts into the byte and increments the pixel counter.
  - When the 8th bit of a group arrives, the following cycle shows wr_en=1 with wr_data and wr_address registered (latency 1 cycle from the last pixel of the group).
  - word_index then increments.
- Frame complete: pixel counter reaches image_width*image_height-1 on a valid pixel. On the same edge that launches the last byte write (wr_en high on the next cycle):
  - image_number <= image_number+1, wrapping 15->0;
  - buf_index toggles;
  - frame_done pulses for one cycle;
  - state returns to ST_WAIT_SOF.
- Early SOF: pix_sof with pix_valid in ST_WRITING before completion aborts the frame.
  - Discard the partial byte; no write is issued for it.
  - Restart at base with the current pixel as pixel 0.
  - buf_index and image_number are unchanged, and bytes already written are overwritten.
- pix_valid low: no state change; wr_en=0 in the following cycle.
- Idle cycles between valid pixels do not affect packing.
- Back-to-back frames: an SOF pixel arriving in the cycle right after completion is accepted normally and written into the new buffer.

Optional Feature:
- Macro: BIT_PIXEL_WRITER_ERRCNT_EN.
- With the macro defined:
  - extra output port frame_err_count[15:0];
  - counts early-SOF aborts plus SOFs seen while pix_valid was low;
  - saturates at 16'hFFFF; cleared by reset.
- Without the macro: the port and the counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package bit_pixel_pkg holds:
  - the shared state enum (ST_WAIT_SOF, ST_WRITING);
  - a function frame_words(width, height) used by both the writer and the reader, so buffer bases agree;
  - PIXELS_PER_WORD = 8.
- Sub-module bit_byte_packer: 8-bit shift register, bit counter and word_strobe, cleared by a restart input. The FSM, address generation and buffering stay in the top level.

Test Plan:
- Reset, then one 8x2 frame (image_width=8, image_height=2, threshold=128, pixels 0,200,0,200,...) -> two writes: 0xAA at address 0, then 0xAA at address 1. image_number goes 0->1, frame_done pulses once, buf_index=1.
- Second identical frame -> writes at addresses 2 and 3. image_number=2, buf_index back to 0.
- SOF re-asserted at pixel 5 of a frame -> no write for the partial byte; next writes restart at the current base. image_number is unchanged; with BIT_PIXEL_WRITER_ERRCNT_EN, frame_err_count=1.
- pix_valid toggled 1-0-1 every cycle across a full frame -> identical wr_data/wr_address sequence to the dense case; wr_en never asserted in gap cycles.
- pclk_reset_n dropped mid-frame, after 3 bytes were written -> all outputs 0 immediately (async). After release, pixels are ignored until SOF, and writes restart at address 0.
- 16 consecutive frames -> image_number wraps 15->0; buffer bases alternate 0/frame_words.
